// File: rtl/dma_pkg.sv
// Shared definitions for the DMA request arbiter: channel sizing, command-register
// bit positions, arbiter state encoding and a one-hot helper.
package dma_pkg;

  localparam int unsigned NCH = 4;
  localparam int unsigned CHW = 2;

  localparam int unsigned CMD_DISABLE   = 2;
  localparam int unsigned CMD_ROTATE    = 4;
  localparam int unsigned CMD_DREQ_LOW  = 6;
  localparam int unsigned CMD_DACK_HIGH = 7;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ARB   = 2'd1,
    GRANT = 2'd2
  } arb_state_t;

  function automatic logic [NCH-1:0] onehot(input logic [CHW-1:0] ch);
    logic [NCH-1:0] v;
    v     = '0;
    v[ch] = 1'b1;
    return v;
  endfunction

endpackage

// File: rtl/dma_prio_encoder.sv
// Combinational priority pick: scans the effective requests starting at the
// highest-priority channel and wrapping around.
module dma_prio_encoder
  import dma_pkg::*;
(
  input  logic [NCH-1:0] eff,
  input  logic [CHW-1:0] topCh,
  output logic [CHW-1:0] winner,
  output logic           found
);

  logic [CHW-1:0] idx;

  always_comb begin
    winner = '0;
    found  = 1'b0;
    idx    = '0;
    for (int unsigned i = 0; i < NCH; i++) begin
      // CHW-bit add wraps modulo NCH because NCH is a power of two
      idx = topCh + CHW'(i);
      if (!found && eff[idx]) begin
        winner = idx;
        found  = 1'b1;
      end
    end
  end

endmodule

// File: rtl/dma_priority_arbiter.sv
// DREQ conditioning and fixed/rotating arbitration in front of the DMA timing
// control; presents one latched grant and drives DACK for the served channel.
module dma_priority_arbiter
  import dma_pkg::*;
(
  input  logic           CLK,
  input  logic           RESET_N,
  input  logic [NCH-1:0] DREQ,
  input  logic [7:0]     cmd_reg,
  input  logic [NCH-1:0] mask_reg,
  input  logic [NCH-1:0] req_reg,
  input  logic           valid_dack,
  input  logic           svc_done,
  output logic [NCH-1:0] VALID_DREQ,
  output logic [NCH-1:0] DACK,
  output logic [CHW-1:0] grant_ch,
  output logic           busy,
  output logic [NCH-1:0] req_pending
);

  arb_state_t     state;
  logic [NCH-1:0] dreqQ;
  logic [NCH-1:0] eff;
  logic [NCH-1:0] validDreq;
  logic [NCH-1:0] dackAct;
  logic [CHW-1:0] grantCh;
  logic [CHW-1:0] prioPtr;
  logic [CHW-1:0] topCh;
  logic [CHW-1:0] winner;
  logic           found;
  logic           busyQ;

  assign eff = (dreqQ & ~mask_reg) | req_reg;

  // Mux keeps a rotate->fixed switch effective at once, before prioPtr clears
  assign topCh = cmd_reg[CMD_ROTATE] ? prioPtr : '0;

  dma_prio_encoder uEnc (
    .eff    (eff),
    .topCh  (topCh),
    .winner (winner),
    .found  (found)
  );

  always_ff @(posedge CLK) begin
    if (!RESET_N) begin
      dreqQ     <= '0;
      state     <= IDLE;
      validDreq <= '0;
      grantCh   <= '0;
      busyQ     <= 1'b0;
      dackAct   <= '0;
      prioPtr   <= '0;
    end else begin
      dreqQ <= DREQ ^ {NCH{cmd_reg[CMD_DREQ_LOW]}};

      case (state)
        IDLE: begin
          if ((|eff) && !cmd_reg[CMD_DISABLE]) state <= ARB;
        end
        ARB: begin
          if (found) begin
            grantCh   <= winner;
            validDreq <= onehot(winner);
            busyQ     <= 1'b1;
            state     <= GRANT;
          end else begin
            state <= IDLE;
          end
        end
        GRANT: begin
          if (svc_done) begin
            validDreq <= '0;
            busyQ     <= 1'b0;
            state     <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase

      if (state == GRANT && valid_dack && !svc_done) dackAct <= onehot(grantCh);
      else dackAct <= '0;

      if (!cmd_reg[CMD_ROTATE]) prioPtr <= '0;
      else if (state == GRANT && svc_done) prioPtr <= grantCh + CHW'(1);
    end
  end

  assign VALID_DREQ  = validDreq;
  assign grant_ch    = grantCh;
  assign busy        = busyQ;
  assign req_pending = eff;
  assign DACK        = dackAct ^ {NCH{~cmd_reg[CMD_DACK_HIGH]}};

endmodule

// File: tb/tb_dma_priority_arbiter.sv
// Self-checking bench for dma_priority_arbiter: directed scenarios plus a
// randomized run against a cycle-level behavioural model.
module tb_dma_priority_arbiter;

  logic       CLK = 1'b0;
  logic       RESET_N;
  logic [3:0] DREQ;
  logic [7:0] cmd_reg;
  logic [3:0] mask_reg;
  logic [3:0] req_reg;
  logic       valid_dack;
  logic       svc_done;
  logic [3:0] VALID_DREQ;
  logic [3:0] DACK;
  logic [1:0] grant_ch;
  logic       busy;
  logic [3:0] req_pending;

  int total = 0;
  int bad   = 0;

  // behavioural model state
  logic [3:0] mDq;
  logic [3:0] mDack;
  bit         mArb;
  bit         mBusy;
  int         mGrant;
  int         mTop;

  always #5 CLK = ~CLK;

  dma_priority_arbiter dut (
    .CLK         (CLK),
    .RESET_N     (RESET_N),
    .DREQ        (DREQ),
    .cmd_reg     (cmd_reg),
    .mask_reg    (mask_reg),
    .req_reg     (req_reg),
    .valid_dack  (valid_dack),
    .svc_done    (svc_done),
    .VALID_DREQ  (VALID_DREQ),
    .DACK        (DACK),
    .grant_ch    (grant_ch),
    .busy        (busy),
    .req_pending (req_pending)
  );

  function automatic int pick(input logic [3:0] e, input int top);
    for (int k = 0; k < 4; k++) if (e[(top + k) % 4]) return (top + k) % 4;
    return 0;
  endfunction

  function automatic logic [3:0] chBit(input int ch);
    logic [3:0] one;
    one = 4'b0001;
    return one << ch;
  endfunction

  function automatic logic [3:0] expValid();
    return mBusy ? chBit(mGrant) : 4'b0000;
  endfunction

  function automatic logic [3:0] expDack();
    return mDack ^ {4{~cmd_reg[7]}};
  endfunction

  // Advance one clock edge and step the model from the inputs seen at that edge.
  task automatic tick();
    logic [3:0] e;
    logic [3:0] nDack;
    @(posedge CLK);
    if (!RESET_N) begin
      mDq = '0; mDack = '0; mArb = 0; mBusy = 0; mGrant = 0; mTop = 0;
    end else begin
      e     = (mDq & ~mask_reg) | req_reg;
      nDack = (mBusy && valid_dack && !svc_done) ? chBit(mGrant) : 4'b0000;
      if (mArb) begin
        mArb = 0;
        if (e != 0) begin
          mBusy  = 1;
          mGrant = pick(e, cmd_reg[4] ? mTop : 0);
        end
      end else if (mBusy) begin
        if (svc_done) begin
          mBusy = 0;
          if (cmd_reg[4]) mTop = (mGrant + 1) % 4;
        end
      end else if (e != 0 && !cmd_reg[2]) begin
        mArb = 1;
      end
      if (!cmd_reg[4]) mTop = 0;
      mDack = nDack;
      mDq   = DREQ ^ {4{cmd_reg[6]}};
    end
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic do_reset(input logic [7:0] cmd);
    RESET_N = 1'b0; DREQ = '0; cmd_reg = cmd; mask_reg = '0; req_reg = '0;
    valid_dack = 1'b0; svc_done = 1'b0;
    tick();
    RESET_N = 1'b1;
  endtask

  task automatic pulse_svc();
    svc_done = 1'b1;
    tick();
    svc_done = 1'b0;
  endtask

  task automatic test_reset();
    do_reset(8'h00);
    total++;
    if (VALID_DREQ !== 4'b0000 || busy !== 1'b0 || grant_ch !== 2'd0) begin
      bad++;
      $display("FAIL reset_state got valid=%b busy=%b ch=%0d want 0000/0/0", VALID_DREQ, busy, grant_ch);
    end
    total++;
    if (DACK !== 4'b1111) begin bad++; $display("FAIL reset_dack got=%b want=1111", DACK); end
  endtask

  task automatic test_fixed_latency();
    do_reset(8'h00);
    DREQ = 4'b1010;
    ticks(2);
    total++;
    if (VALID_DREQ !== 4'b0000) begin bad++; $display("FAIL lat_early got=%b want=0000", VALID_DREQ); end
    tick();
    total++;
    if (VALID_DREQ !== 4'b0010 || grant_ch !== 2'd1 || busy !== 1'b1) begin
      bad++; $display("FAIL lat_grant got valid=%b ch=%0d busy=%b want 0010/1/1", VALID_DREQ, grant_ch, busy);
    end
    total++;
    if (req_pending !== 4'b1010) begin bad++; $display("FAIL req_pending got=%b want=1010", req_pending); end
    DREQ = 4'b1000;
    pulse_svc();
    tick();
    total++;
    if (VALID_DREQ !== 4'b0000) begin bad++; $display("FAIL b2b_gap got=%b want=0000", VALID_DREQ); end
    tick();
    total++;
    if (VALID_DREQ !== 4'b1000 || grant_ch !== 2'd3) begin
      bad++; $display("FAIL b2b_next got valid=%b ch=%0d want 1000/3", VALID_DREQ, grant_ch);
    end
  endtask

  task automatic test_rotate();
    int order [5] = '{0, 1, 2, 3, 0};
    do_reset(8'h10);
    DREQ = 4'b1111;
    ticks(3);
    for (int i = 0; i < 5; i++) begin
      total++;
      if (busy !== 1'b1 || grant_ch !== order[i][1:0]) begin
        bad++; $display("FAIL rotate_%0d got ch=%0d busy=%b want ch=%0d", i, grant_ch, busy, order[i]);
      end
      pulse_svc();
      ticks(2);
    end
  endtask

  task automatic test_polarity();
    do_reset(8'hC0);
    DREQ = 4'b1110;
    ticks(3);
    total++;
    if (VALID_DREQ !== 4'b0001) begin bad++; $display("FAIL pol_grant got=%b want=0001", VALID_DREQ); end
    total++;
    if (DACK !== 4'b0000) begin bad++; $display("FAIL pol_dack_idle got=%b want=0000", DACK); end
    valid_dack = 1'b1;
    tick();
    total++;
    if (DACK !== 4'b0001) begin bad++; $display("FAIL pol_dack_hi got=%b want=0001", DACK); end
    cmd_reg = 8'h40;
    #1;
    total++;
    if (DACK !== 4'b1110) begin bad++; $display("FAIL pol_dack_lo got=%b want=1110", DACK); end
    valid_dack = 1'b0;
    tick();
    total++;
    if (DACK !== 4'b1111 || VALID_DREQ !== 4'b0001) begin
      bad++; $display("FAIL pol_dack_fall got dack=%b valid=%b want 1111/0001", DACK, VALID_DREQ);
    end
    pulse_svc();
  endtask

  task automatic test_mask_swreq();
    do_reset(8'h00);
    mask_reg = 4'b0001; DREQ = 4'b0101; req_reg = 4'b0001;
    ticks(3);
    total++;
    if (grant_ch !== 2'd0 || busy !== 1'b1) begin
      bad++; $display("FAIL swreq_ch0 got ch=%0d busy=%b want 0/1", grant_ch, busy);
    end
    req_reg = 4'b0000;
    pulse_svc();
    ticks(2);
    total++;
    if (grant_ch !== 2'd2 || VALID_DREQ !== 4'b0100) begin
      bad++; $display("FAIL mask_ch2 got ch=%0d valid=%b want 2/0100", grant_ch, VALID_DREQ);
    end
    pulse_svc();
  endtask

  task automatic test_disable();
    do_reset(8'h00);
    DREQ = 4'b0010;
    ticks(3);
    cmd_reg = 8'h04;
    ticks(3);
    total++;
    if (VALID_DREQ !== 4'b0010 || grant_ch !== 2'd1) begin
      bad++; $display("FAIL dis_hold got valid=%b ch=%0d want 0010/1", VALID_DREQ, grant_ch);
    end
    pulse_svc();
    total++;
    if (busy !== 1'b0) begin bad++; $display("FAIL dis_release got busy=%b want 0", busy); end
    for (int i = 0; i < 6; i++) begin
      tick();
      total++;
      if (VALID_DREQ !== 4'b0000) begin bad++; $display("FAIL dis_block_%0d got=%b want=0000", i, VALID_DREQ); end
    end
    cmd_reg = 8'h00;
    tick();
    total++;
    if (VALID_DREQ !== 4'b0000) begin bad++; $display("FAIL en_early got=%b want=0000", VALID_DREQ); end
    tick();
    total++;
    if (VALID_DREQ !== 4'b0010) begin bad++; $display("FAIL en_grant got=%b want=0010", VALID_DREQ); end
    pulse_svc();
  endtask

  task automatic test_reset_midgrant();
    do_reset(8'h10);
    DREQ = 4'b1111;
    ticks(3);
    pulse_svc();
    ticks(2);
    valid_dack = 1'b1;
    tick();
    total++;
    if (grant_ch !== 2'd1 || DACK !== 4'b1101) begin
      bad++; $display("FAIL mid_pre got ch=%0d dack=%b want 1/1101", grant_ch, DACK);
    end
    RESET_N = 1'b0;
    tick();
    total++;
    if (VALID_DREQ !== 4'b0000 || busy !== 1'b0 || DACK !== 4'b1111) begin
      bad++; $display("FAIL mid_reset got valid=%b busy=%b dack=%b want 0000/0/1111", VALID_DREQ, busy, DACK);
    end
    RESET_N = 1'b1; valid_dack = 1'b0;
    ticks(3);
    total++;
    if (grant_ch !== 2'd0 || busy !== 1'b1) begin
      bad++; $display("FAIL mid_ptr got ch=%0d busy=%b want 0/1", grant_ch, busy);
    end
  endtask

  task automatic test_withdraw();
    do_reset(8'h00);
    DREQ = 4'b0100;
    tick();
    DREQ = 4'b0000;
    for (int i = 0; i < 4; i++) begin
      tick();
      total++;
      if (VALID_DREQ !== 4'b0000 || busy !== 1'b0) begin
        bad++; $display("FAIL withdraw_%0d got valid=%b busy=%b want 0000/0", i, VALID_DREQ, busy);
      end
    end
  endtask

  task automatic test_random();
    do_reset(8'h00);
    for (int n = 0; n < 1500; n++) begin
      RESET_N    = ($urandom_range(0, 99) != 0);
      DREQ       = 4'($urandom);
      mask_reg   = 4'($urandom) & 4'($urandom);
      req_reg    = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'b0000;
      cmd_reg    = {1'($urandom), 1'($urandom), 1'b0, ($urandom_range(0, 1) == 0), 1'b0,
                    ($urandom_range(0, 7) == 0), 2'b00};
      valid_dack = 1'($urandom);
      svc_done   = ($urandom_range(0, 3) == 0);
      tick();
      total++;
      if (VALID_DREQ !== expValid() || busy !== mBusy || grant_ch !== 2'(mGrant)) begin
        bad++;
        $display("FAIL rnd_grant n=%0d got valid=%b busy=%b ch=%0d want %b/%b/%0d",
                 n, VALID_DREQ, busy, grant_ch, expValid(), mBusy, mGrant);
      end
      total++;
      if (DACK !== expDack() || $countones(DACK ^ {4{~cmd_reg[7]}}) > 1) begin
        bad++; $display("FAIL rnd_dack n=%0d got=%b want=%b", n, DACK, expDack());
      end
      total++;
      if (req_pending !== ((mDq & ~mask_reg) | req_reg)) begin
        bad++; $display("FAIL rnd_pending n=%0d got=%b want=%b", n, req_pending, (mDq & ~mask_reg) | req_reg);
      end
    end
  endtask

  initial begin
    test_reset();
    test_fixed_latency();
    test_rotate();
    test_polarity();
    test_mask_swreq();
    test_disable();
    test_reset_midgrant();
    test_withdraw();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
